// File: rtl/serial_add_ctrl_if.sv
// Handshake and data bundle for serial_add_ctrl.
// The sub select exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB-first over WIDTH bits.
// Optional macro SERIAL_ADD_SUB_EN adds a sub select (a - b, cout = no borrow).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic             w_bit;
  logic             w_c;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
  assign w_b_load = bus.sub ? ~bus.b : bus.b;
  assign w_c_load = bus.sub | bus.cin;
`else
  assign w_b_load = bus.b;
  assign w_c_load = bus.cin;
`endif

  assign w_bit = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_c   = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));

  // NOTE: all state uses non-blocking assignment so every register samples
  // the pre-edge values of its neighbours, exactly like the hardware flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift registers are plain flops, not a RAM, so resetting
      // them is cheap and keeps an abandoned operation from leaking state.
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_s_sr  <= {w_bit, r_s_sr[WIDTH-1:1]};
          r_carry <= w_c;
          if (r_cnt == LAST) begin
            // Publish the full result, final bit included, in one step.
            r_sum   <= {w_bit, r_s_sr[WIDTH-1:1]};
            r_cout  <= w_c;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8 plus a WIDTH=2 sweep).
// Define SERIAL_ADD_SUB_EN to also exercise subtraction.
module tb_serial_add_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_ctrl #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the 8-bit DUT and check it cycle by cycle.
  // Ends in the DONE cycle so a caller can chain a back-to-back start.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [7:0] exp_sum, input logic exp_cout,
                        input string name);
    logic [7:0] prev_sum;
    logic       prev_cout;
    prev_sum  = bus8.sum;
    prev_cout = bus8.cout;
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = sub;
`else
    if (sub) $display("note: %s requests sub on an add-only build", name);
`endif
    tick();
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
        bad++;
        $display("FAIL %s run cycle %0d: busy=%b done=%b, want busy=1 done=0", name, i, bus8.busy, bus8.done);
      end
      total++;
      if (bus8.sum !== prev_sum || bus8.cout !== prev_cout) begin
        bad++;
        $display("FAIL %s hold cycle %0d: sum=%h cout=%b, want sum=%h cout=%b", name, i, bus8.sum, bus8.cout, prev_sum, prev_cout);
      end
      tick();
    end
    total++;
    if (bus8.done !== 1'b1 || bus8.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s done: done=%b busy=%b, want done=1 busy=0", name, bus8.done, bus8.busy);
    end
    total++;
    if (bus8.sum !== exp_sum || bus8.cout !== exp_cout) begin
      bad++;
      $display("FAIL %s result: sum=%h cout=%b, want sum=%h cout=%b", name, bus8.sum, bus8.cout, exp_sum, exp_cout);
    end
  endtask

  task automatic expect_idle(input string name);
    tick();
    total++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: done=%b busy=%b, want 0/0", name, bus8.done, bus8.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h9E; bus8.cin = 1'b1;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = 1'b0; bus2.sub = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold %0d: busy=%b done=%b sum=%h cout=%b, want all 0", i, bus8.busy, bus8.done, bus8.sum, bus8.cout);
      end
    end
    bus8.start = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) expect_idle("reset_release");
  endtask

  task automatic test_basic_add();
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "basic_add");
    expect_idle("basic_add");
  endtask

  task automatic test_carry_ripple();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "ripple_ff_01");
    expect_idle("ripple_ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "ripple_ff_ff_c");
    expect_idle("ripple_ff_ff_c");
    run_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, "ripple_cin_only");
    expect_idle("ripple_cin_only");
  endtask

  task automatic test_start_while_busy();
    int dones;
    dones = 0;
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus8.done === 1'b1) dones++;
      tick();
    end
    total++;
    if (dones != 0 || bus8.done !== 1'b1) begin
      bad++;
      $display("FAIL busy_start timing: early dones=%0d done=%b, want 0 and 1", dones, bus8.done);
    end
    total++;
    if (bus8.sum !== 8'h30 || bus8.cout !== 1'b0) begin
      bad++;
      $display("FAIL busy_start result: sum=%h cout=%b, want sum=30 cout=0", bus8.sum, bus8.cout);
    end
  endtask

  task automatic test_back_to_back();
    // Entered in the DONE cycle left by test_start_while_busy.
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, "back_to_back");
    expect_idle("back_to_back");
  endtask

  task automatic test_reset_mid_op();
    int dones;
    dones = 0;
    bus8.a = 8'h7F; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, want all 0", bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_mid_abandon: active cycles=%0d, want 0", dones);
    end
    run_op(8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 1'b0, "after_reset");
    expect_idle("after_reset");
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_subtract();
    run_op(8'h10, 8'h03, 1'b1, 1'b1, 8'h0D, 1'b1, "sub_no_borrow");
    expect_idle("sub_no_borrow");
    run_op(8'h03, 8'h10, 1'b0, 1'b1, 8'hF3, 1'b0, "sub_borrow");
    expect_idle("sub_borrow");
  endtask
`endif

  // All {a[0], b[0], cin} on the 2-bit DUT against a reference sum.
  task automatic test_width2_sweep();
    logic [1:0] a2, b2;
    logic       c2;
    logic [2:0] exp;
    int         nsub;
`ifdef SERIAL_ADD_SUB_EN
    nsub = 2;
`else
    nsub = 1;
`endif
    for (int s = 0; s < nsub; s++) begin
      for (int v = 0; v < 8; v++) begin
        a2 = {1'b1, v[2]};
        b2 = {v[0], v[1]};
        c2 = v[0];
        if (s == 0) exp = {1'b0, a2} + {1'b0, b2} + {2'b00, c2};
        else        exp = {1'b0, a2} + {1'b0, ~b2} + 3'd1;
        bus2.a = a2; bus2.b = b2; bus2.cin = c2; bus2.start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        bus2.sub = (s == 1);
`endif
        tick();
        bus2.start = 1'b0;
        tick();
        tick();
        total++;
        if (bus2.done !== 1'b1 || {bus2.cout, bus2.sum} !== exp) begin
          bad++;
          $display("FAIL w2_sweep s=%0d v=%0d: done=%b cout_sum=%b, want done=1 cout_sum=%b", s, v, bus2.done, {bus2.cout, bus2.sum}, exp);
        end
        tick();
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
`ifdef SERIAL_ADD_SUB_EN
    test_subtract();
`endif
    test_width2_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
